read_i2c: RTL and testbench



---
 rtl/read_i2c_if.sv | 14 +
 rtl/read_i2c.sv | 135 +++++++++++++
 tb/tb_read_i2c.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/read_i2c_if.sv
// Request/response bundle between the configuration controller and the
// SCCB register-read master.
`timescale 1us/1ns
interface read_i2c_if;
    logic [23:0] rd_addr;
    logic        rd_req;
    logic [7:0]  rd_data;
    logic        rd_ack;
    logic        ack_err;
    logic        busy;

    modport master (output rd_addr, rd_req, input rd_data, rd_ack, ack_err, busy);
    modport slave  (input rd_addr, rd_req, output rd_data, rd_ack, ack_err, busy);
endinterface

// File: rtl/read_i2c.sv
// SCCB/I2C single-byte register read: write-address phase, STOP, read phase
// ending with master NACK and STOP. One bus bit per clk_20k period.
`timescale 1us/1ns
module read_i2c (
    input  logic       clk_20k,
    input  logic       rst_100,
    read_i2c_if.slave  rd,
    output logic       sclk,
    inout  wire        sda
);
    logic [5:0]  step_p0;
    logic        armed;
    logic        accept;
    logic [6:0]  dev_p0;
    logic [15:0] reg_p0;
    logic        unused_addr_bit;

    logic [7:0]  wr_byte, rd_byte, hi_byte, lo_byte;
    logic        sda_d, scl_d, gate_d;

    logic        sda_p1, scl_p1, gate_p1;
    logic [5:0]  slot_p1;
    logic        rd_ack_p1, busy_p1, ack_err_p1;
    logic [7:0]  rd_data_p1;

    logic        ack_acc;
    logic [7:0]  shift_n;

    assign unused_addr_bit = rd.rd_addr[16];
    assign accept = (step_p0 == 6'd0) && rd.rd_req && armed;

    // Stage p0: step counter runs one slot ahead of the pins
    always_ff @(posedge clk_20k or negedge rst_100) begin
        if (!rst_100) begin
            step_p0 <= 6'd0;
            armed   <= 1'b1;
        end else begin
            if (accept)
                step_p0 <= 6'd1;
            else if (step_p0 == 6'd57)
                step_p0 <= 6'd0;
            else if (step_p0 != 6'd0)
                step_p0 <= step_p0 + 6'd1;

            if (!rd.rd_req)
                armed <= 1'b1;
            else if (accept)
                armed <= 1'b0;
        end
    end

    always_ff @(posedge clk_20k) begin
        if (accept) begin
            dev_p0 <= rd.rd_addr[23:17];
            reg_p0 <= rd.rd_addr[15:0];
        end
    end

    assign wr_byte = {dev_p0, 1'b0};
    assign rd_byte = {dev_p0, 1'b1};
    assign hi_byte = reg_p0[15:8];
    assign lo_byte = reg_p0[7:0];

    // Bit index within a byte is (last_step - step) mod 8, taken on the low 3 bits
    always_comb begin
        sda_d  = 1'b1;
        scl_d  = 1'b1;
        gate_d = 1'b0;
        if (step_p0 inside {6'd1, 6'd31, 6'd34, 6'd55}) begin
            sda_d = 1'b0;
        end else if (step_p0 inside {6'd2, 6'd30, 6'd35, 6'd54}) begin
            sda_d = 1'b0;
            scl_d = 1'b0;
        end else if (step_p0 inside {[6'd3:6'd29], [6'd36:6'd53]}) begin
            gate_d = 1'b1;
            scl_d  = 1'b0;
            if (step_p0 inside {[6'd3:6'd10]})
                sda_d = wr_byte[3'd2 - step_p0[2:0]];
            else if (step_p0 inside {[6'd12:6'd19]})
                sda_d = hi_byte[3'd3 - step_p0[2:0]];
            else if (step_p0 inside {[6'd21:6'd28]})
                sda_d = lo_byte[3'd4 - step_p0[2:0]];
            else if (step_p0 inside {[6'd36:6'd43]})
                sda_d = rd_byte[3'd3 - step_p0[2:0]];
        end
    end

    // Stage p1: pin registers and host-side outputs
    always_ff @(posedge clk_20k or negedge rst_100) begin
        if (!rst_100) begin
            sda_p1     <= 1'b1;
            scl_p1     <= 1'b1;
            gate_p1    <= 1'b0;
            slot_p1    <= 6'd0;
            rd_ack_p1  <= 1'b0;
            busy_p1    <= 1'b0;
            ack_err_p1 <= 1'b0;
            rd_data_p1 <= 8'h00;
        end else begin
            sda_p1    <= sda_d;
            scl_p1    <= scl_d;
            gate_p1   <= gate_d;
            slot_p1   <= step_p0;
            rd_ack_p1 <= (step_p0 == 6'd57);
            busy_p1   <= accept || (step_p0 != 6'd0);
            if (step_p0 == 6'd57) begin
                ack_err_p1 <= ack_acc;
                rd_data_p1 <= shift_n;
            end
        end
    end

    // Falling-edge sampling lands mid SCL-high in gated slots
    always_ff @(negedge clk_20k or negedge rst_100) begin
        if (!rst_100)
            ack_acc <= 1'b0;
        else if (slot_p1 == 6'd1)
            ack_acc <= 1'b0;
        else if (slot_p1 inside {6'd11, 6'd20, 6'd29, 6'd44})
            ack_acc <= ack_acc | sda;
    end

    always_ff @(negedge clk_20k) begin
        if (slot_p1 inside {[6'd45:6'd52]})
            shift_n <= {shift_n[6:0], sda};
    end

    assign sclk = gate_p1 ? ~clk_20k : scl_p1;
    assign sda  = sda_p1 ? 1'bz : 1'b0;

    assign rd.rd_ack  = rd_ack_p1;
    assign rd.busy    = busy_p1;
    assign rd.ack_err = ack_err_p1;
    assign rd.rd_data = rd_data_p1;
endmodule

// File: tb/tb_read_i2c.sv
// Scoreboard bench for read_i2c with a bus-level SCCB slave model.
`timescale 1us/1ns
module tb_read_i2c;
    logic clk_20k = 1'b0;
    logic rst_100 = 1'b0;
    wire  sclk;
    wire  sda;
    logic slave_low = 1'b0;

    read_i2c_if rif();

    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);

    read_i2c dut (.clk_20k(clk_20k), .rst_100(rst_100), .rd(rif.slave), .sclk(sclk), .sda(sda));

    always #25 clk_20k = ~clk_20k;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] bus_exp_q[$];

    int   checks = 0;
    int   failures = 0;
    int   tb_cyc = 0;
    int   ack_cnt = 0;
    int   hi_trans = 0;
    bit   bus_chk = 1'b1;
    bit   slave_present = 1'b1;
    bit   nack_lo = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem(input logic [15:0] r);
        return (r == 16'h300A) ? 8'hA5 : (r[15:8] ^ r[7:0] ^ 8'h3C);
    endfunction

    always @(posedge clk_20k) tb_cyc++;

    // Host-side monitor: every rd_ack pops one expectation
    logic prev_ack = 1'b0;
    always @(negedge clk_20k) begin
        if (prev_ack) begin
            chk("busy_after_ack", rif.busy, 1'b0);
            chk("ack_single_cycle", rif.rd_ack, 1'b0);
        end
        prev_ack = (rif.rd_ack === 1'b1);
        if (rif.rd_ack === 1'b1) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_ack actual=1 expected=0 at cycle %0d", tb_cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_data", rif.rd_data, e.data);
                chk("ack_err", rif.ack_err, e.err);
                chk("latency", tb_cyc - e.acc, 57);
                chk("busy_at_ack", rif.busy, 1'b1);
            end
        end
    end

    // Bus sampler and slave: sampled 1 us after every clock edge
    logic       p_scl = 1'b1, p_sda = 1'b1;
    logic [8:0] sh = '0;
    int         nb = 0, byte_i = 0;
    bit         frame_rd = 1'b0, sel = 1'b0;
    logic [15:0] reg_ptr = '0;
    always begin
        logic c_scl, c_sda;
        logic [7:0] d;
        @(clk_20k);
        #1;
        c_scl = sclk;
        c_sda = sda;
        if (!rst_100) begin
            slave_low = 1'b0; nb = 0; byte_i = 0; sel = 1'b0;
        end else if (p_scl && c_scl && (p_sda !== c_sda)) begin
            hi_trans++;
            nb = 0; byte_i = 0; sel = 1'b0; slave_low = 1'b0;
        end else if (!p_scl && c_scl) begin
            sh = {sh[7:0], c_sda};
            nb++;
            if (nb == 8) begin
                if (byte_i == 0) begin
                    frame_rd = sh[0];
                    sel = slave_present && (sh[7:1] == 7'h3C);
                end else if (!frame_rd && byte_i == 1) reg_ptr[15:8] = sh[7:0];
                else if (!frame_rd && byte_i == 2) reg_ptr[7:0] = sh[7:0];
            end
            if (nb == 9) begin
                if (bus_chk) begin
                    if (bus_exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_bus_byte actual=%0h expected=none", sh);
                    end else begin
                        chk("bus_byte", sh, bus_exp_q.pop_front());
                    end
                end
                nb = 0;
                byte_i++;
            end
        end else if (p_scl && !c_scl) begin
            slave_low = 1'b0;
            if (nb == 8) begin
                if (sel && (frame_rd ? (byte_i == 0) : (byte_i < 2 || (byte_i == 2 && !nack_lo))))
                    slave_low = 1'b1;
            end else if (sel && frame_rd && byte_i == 1) begin
                d = mem(reg_ptr);
                slave_low = ~d[3'(7 - nb)];
            end
        end
        p_scl = c_scl;
        p_sda = c_sda;
    end

    // Reference model: expected host result and bus bytes with their ACK bits
    task automatic push_exp(input logic [6:0] dev, input logic [15:0] rg, input bit present, input bit nlo);
        exp_t e;
        logic match;
        slave_present = present;
        nack_lo = nlo;
        match = present && (dev == 7'h3C);
        e.data = match ? mem(rg) : 8'hFF;
        e.err  = !match || nlo;
        bus_exp_q.push_back({dev, 1'b0, !match});
        bus_exp_q.push_back({rg[15:8], !match});
        bus_exp_q.push_back({rg[7:0], !match || nlo});
        bus_exp_q.push_back({dev, 1'b1, !match});
        bus_exp_q.push_back({e.data, 1'b1});
        e.acc = tb_cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int n0, input int budget);
        for (int i = 0; i < budget && ack_cnt == n0; i++) @(negedge clk_20k);
        chk("rd_ack_seen", ack_cnt - n0, 1);
    endtask

    task automatic run_txn(input logic [6:0] dev, input logic [15:0] rg, input bit present, input bit nlo);
        int n0;
        repeat (2) @(negedge clk_20k);
        hi_trans = 0;
        n0 = ack_cnt;
        rif.rd_addr = {dev, 1'($urandom_range(0, 1)), rg};
        rif.rd_req = 1'b1;
        push_exp(dev, rg, present, nlo);
        @(negedge clk_20k);
        chk("busy_after_accept", rif.busy, 1'b1);
        rif.rd_req = 1'b0;
        wait_ack(n0, 80);
        chk("start_stop_edges", hi_trans, 4);
        chk("bus_bytes_left", bus_exp_q.size(), 0);
    endtask

    initial begin
        int n0, acc;
        rif.rd_addr = '0;
        rif.rd_req  = 1'b0;
        repeat (3) @(negedge clk_20k);
        chk("rst_sclk", sclk, 1'b1);
        chk("rst_sda", sda, 1'b1);
        chk("rst_rd_ack", rif.rd_ack, 1'b0);
        chk("rst_busy", rif.busy, 1'b0);
        chk("rst_ack_err", rif.ack_err, 1'b0);
        chk("rst_rd_data", rif.rd_data, 8'h00);
        rst_100 = 1'b1;

        run_txn(7'h3C, 16'h300A, 1'b1, 1'b0);
        run_txn(7'h3C, 16'h0042, 1'b0, 1'b0);
        run_txn(7'h3C, 16'h1234, 1'b1, 1'b1);

        // Level held high: one transaction only, then re-arm with a one-cycle drop
        repeat (2) @(negedge clk_20k);
        hi_trans = 0;
        n0 = ack_cnt;
        rif.rd_addr = {7'h3C, 1'b0, 16'h5A01};
        rif.rd_req = 1'b1;
        push_exp(7'h3C, 16'h5A01, 1'b1, 1'b0);
        repeat (200) @(negedge clk_20k);
        chk("held_req_acks", ack_cnt - n0, 1);
        chk("held_req_edges", hi_trans, 4);
        rif.rd_req = 1'b0;
        @(negedge clk_20k);
        hi_trans = 0;
        n0 = ack_cnt;
        rif.rd_addr = {7'h3C, 1'b1, 16'h0F0F};
        rif.rd_req = 1'b1;
        push_exp(7'h3C, 16'h0F0F, 1'b1, 1'b0);
        wait_ack(n0, 80);
        chk("rearm_edges", hi_trans, 4);
        rif.rd_req = 1'b0;

        // Reset in slot 40 aborts silently
        repeat (3) @(negedge clk_20k);
        bus_chk = 1'b0;
        n0 = ack_cnt;
        rif.rd_addr = {7'h3C, 1'b0, 16'h300A};
        rif.rd_req = 1'b1;
        acc = tb_cyc + 1;
        @(negedge clk_20k);
        rif.rd_req = 1'b0;
        while (tb_cyc < acc + 40) @(negedge clk_20k);
        rst_100 = 1'b0;
        #1;
        chk("abort_sda", sda, 1'b1);
        chk("abort_sclk", sclk, 1'b1);
        chk("abort_busy", rif.busy, 1'b0);
        repeat (2) @(negedge clk_20k);
        rst_100 = 1'b1;
        repeat (70) @(negedge clk_20k);
        chk("abort_no_ack", ack_cnt - n0, 0);
        bus_chk = 1'b1;
        run_txn(7'h3C, 16'h300A, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [6:0] dev;
            dev = ($urandom_range(0, 1) == 0) ? 7'h3C : 7'($urandom);
            run_txn(dev, 16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk_20k);
        chk("exp_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
